// File: rtl/pixel_fb_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fb_writer_pkg
// Description : Shared types and default framebuffer geometry for the pixel
//               write path (tile drawer, framebuffer writer, VGA output).
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_fb_writer_pkg;

  // Default framebuffer geometry, shared with the tile drawer and VGA output
  localparam int DEF_FB_WIDTH   = 160;
  localparam int DEF_FB_HEIGHT  = 120;
  localparam int DEF_COLOR_BITS = 9;
  localparam int DEF_ADDR_W     = 15;

  // Writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_e;

  // One pixel as delivered by the tile drawer
  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
  } pixel_t;

endpackage : pixel_fb_writer_pkg
`default_nettype wire

// File: rtl/pixel_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fb_writer_if
// Description : Framebuffer RAM write port (we/ready handshake).
//               The writer drives the request side, the RAM drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_fb_writer_if #(
  parameter int ADDR_W     = 15,
  parameter int COLOR_BITS = 9
) ();

  logic                  fb_we;
  logic [ADDR_W-1:0]     fb_addr;
  logic [COLOR_BITS-1:0] fb_data;
  logic                  fb_ready;

  modport master (
    output fb_we,
    output fb_addr,
    output fb_data,
    input  fb_ready
  );

  modport slave (
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    output fb_ready
  );

endinterface : pixel_fb_writer_if
`default_nettype wire

// File: rtl/pixel_fb_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous FIFO, parameterised width and power-of-2 depth.
//               A push while full is accepted when a pop happens on the
//               same edge. Pops on an empty FIFO are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       resetn,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           push_data,
  input  wire logic                       pop,
  output      logic [WIDTH-1:0]           pop_data,
  output      logic                       full,
  output      logic                       empty,
  output      logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : pixel_fifo
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fb_writer
// Description : Buffers the tile drawer's pixel stream, converts (x, y) to a
//               linear framebuffer address, reduces RGB888 to the framebuffer
//               colour depth and writes it over a we/ready handshake. Also
//               fills the whole screen with a background colour on request.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
#(
  parameter int FB_WIDTH   = DEF_FB_WIDTH,
  parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  wire logic                  clk,
  input  wire logic                  resetn,
  input  wire logic                  pix_valid,
  input  wire logic [7:0]            pix_x,
  input  wire logic [7:0]            pix_y,
  input  wire logic [23:0]           pix_rgb,
  input  wire logic                  clear_req,
  input  wire logic [COLOR_BITS-1:0] bg_color,
  input  wire logic                  clear_err,
  pixel_fb_writer_if.master          fb,
  output      logic                  busy,
  output      logic                  clear_done,
  output      logic                  err_overflow,
  output      logic                  err_oob
);

  localparam int                CH_BITS   = COLOR_BITS / 3;
  localparam int                FIFO_CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [8:0]        WIDTH_9   = 9'(FB_WIDTH);
  localparam logic [8:0]        HEIGHT_9  = 9'(FB_HEIGHT);

  fb_state_e             state_q, state_d;
  logic                  fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
  logic [COLOR_BITS-1:0] fb_data_q, fb_data_d;
  logic                  clear_pending_q, clear_pending_d;
  logic                  clear_done_q, clear_done_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_oob_q, err_oob_d;

  pixel_t                pix_in;
  pixel_t                head;
  logic                  in_range;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CW-1:0]    fifo_count;
  logic                  write_done;
  logic                  start_next;
  logic [ADDR_W-1:0]     head_addr;
  logic [COLOR_BITS-1:0] head_color;

  // ---------------------------------------------------------------- input side
  assign pix_in    = '{x: pix_x, y: pix_y, rgb: pix_rgb};
  assign in_range  = ({1'b0, pix_x} < WIDTH_9) && ({1'b0, pix_y} < HEIGHT_9);
  // A full FIFO can still take the pixel if the FSM pops on this same edge
  assign fifo_push = pix_valid && in_range && (!fifo_full || fifo_pop);

  pixel_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (pix_in),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // --------------------------------------------- address and colour from head
  assign head_addr  = ADDR_W'(head.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head.x);
  assign head_color = {head.rgb[23 -: CH_BITS], head.rgb[15 -: CH_BITS],
                       head.rgb[7 -: CH_BITS]};

  assign write_done = fb_we_q && fb.fb_ready;

  // Next-state logic: clear beats the FIFO whenever a new write can be issued
  always_comb begin
    state_d         = state_q;
    fb_we_d         = fb_we_q;
    fb_addr_d       = fb_addr_q;
    fb_data_d       = fb_data_q;
    clear_pending_d = clear_pending_q;
    clear_done_d    = 1'b0;
    fifo_pop        = 1'b0;
    start_next      = 1'b0;

    case (state_q)
      ST_IDLE:  start_next = 1'b1;
      ST_WRITE: start_next = write_done;
      ST_CLEAR: begin
        if (write_done) begin
          if (fb_addr_q == LAST_ADDR) begin
            fb_we_d      = 1'b0;
            clear_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            fb_addr_d = fb_addr_q + ADDR_W'(1);
            fb_data_d = bg_color;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Issuing from WRITE on completion keeps fb_we high for 1 pixel/clk
    if (start_next) begin
      if (clear_pending_q) begin
        clear_pending_d = 1'b0;
        fb_we_d         = 1'b1;
        fb_addr_d       = '0;
        fb_data_d       = bg_color;
        state_d         = ST_CLEAR;
      end else if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        fb_we_d   = 1'b1;
        fb_addr_d = head_addr;
        fb_data_d = head_color;
        state_d   = ST_WRITE;
      end else begin
        fb_we_d = 1'b0;
        state_d = ST_IDLE;
      end
    end

    // A request during a clear or with one already queued is dropped
    if (clear_req && (state_q != ST_CLEAR) && !clear_pending_q) begin
      clear_pending_d = 1'b1;
    end
  end

  // Sticky error flags: a new event wins over a simultaneous clear_err
  always_comb begin
    err_overflow_d = (pix_valid && in_range && fifo_full && !fifo_pop) ||
                     (err_overflow_q && !clear_err);
    err_oob_d      = (pix_valid && !in_range) || (err_oob_q && !clear_err);
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      fb_we_q         <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= '0;
      clear_pending_q <= 1'b0;
      clear_done_q    <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_oob_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      fb_we_q         <= fb_we_d;
      fb_addr_q       <= fb_addr_d;
      fb_data_q       <= fb_data_d;
      clear_pending_q <= clear_pending_d;
      clear_done_q    <= clear_done_d;
      err_overflow_q  <= err_overflow_d;
      err_oob_q       <= err_oob_d;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign fb.fb_we     = fb_we_q;
  assign fb.fb_addr   = fb_addr_q;
  assign fb.fb_data   = fb_data_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty || clear_pending_q;
  assign clear_done   = clear_done_q;
  assign err_overflow = err_overflow_q;
  assign err_oob      = err_oob_q;

endmodule : pixel_fb_writer
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fb_writer
// Description : Directed self-checking bench for pixel_fb_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fb_writer;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_x     = '0;
  logic [7:0]  pix_y     = '0;
  logic [23:0] pix_rgb   = '0;
  logic        clear_req = 1'b0;
  logic [8:0]  bg_color  = '0;
  logic        clear_err = 1'b0;
  logic        busy;
  logic        clear_done;
  logic        err_overflow;
  logic        err_oob;

  int n_pass  = 0;
  int n_total = 0;

  logic [14:0] wr_addr [$];
  logic [8:0]  wr_data [$];
  int          done_cnt = 0;

  pixel_fb_writer_if #(.ADDR_W(15), .COLOR_BITS(9)) fb_if ();

  pixel_fb_writer #(
    .FB_WIDTH   (160),
    .FB_HEIGHT  (120),
    .ADDR_W     (15),
    .FIFO_DEPTH (8),
    .COLOR_BITS (9)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .clear_req    (clear_req),
    .bg_color     (bg_color),
    .clear_err    (clear_err),
    .fb           (fb_if),
    .busy         (busy),
    .clear_done   (clear_done),
    .err_overflow (err_overflow),
    .err_oob      (err_oob)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge, so at the falling edge a
  // we&&ready pair is exactly the handshake the next rising edge completes.
  always @(negedge clk) begin
    if (resetn) begin
      if (fb_if.fb_we && fb_if.fb_ready) begin
        wr_addr.push_back(fb_if.fb_addr);
        wr_data.push_back(fb_if.fb_data);
      end
      if (clear_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic strobe(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb);
    pix_valid = 1'b1;
    pix_x     = x;
    pix_y     = y;
    pix_rgb   = rgb;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    fb_if.fb_ready = 1'b0;
    tick(); tick();
    n_total++; if (fb_if.fb_we !== 1'b0) $display("FAIL reset_we: got %b want 0", fb_if.fb_we); else n_pass++;
    n_total++; if (fb_if.fb_addr !== 15'd0) $display("FAIL reset_addr: got %0d want 0", fb_if.fb_addr); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if ({clear_done, err_overflow, err_oob} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {clear_done, err_overflow, err_oob}); else n_pass++;
    resetn = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    fb_if.fb_ready = 1'b1;
    clear_log();
    strobe(8'd5, 8'd2, 24'hFF8000);
    // Pushed at E0; the FSM has not popped it yet
    n_total++; if (fb_if.fb_we !== 1'b0) $display("FAIL single_we_e0: got %b want 0", fb_if.fb_we); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy_e0: got %b want 1", busy); else n_pass++;
    tick();
    n_total++; if (fb_if.fb_we !== 1'b1) $display("FAIL single_we_e1: got %b want 1", fb_if.fb_we); else n_pass++;
    n_total++; if (fb_if.fb_addr !== 15'd325) $display("FAIL single_addr: got %0d want 325", fb_if.fb_addr); else n_pass++;
    n_total++; if (fb_if.fb_data !== 9'b111100000) $display("FAIL single_data: got %b want 111100000", fb_if.fb_data); else n_pass++;
    tick();
    n_total++; if (fb_if.fb_we !== 1'b0) $display("FAIL single_we_e2: got %b want 0", fb_if.fb_we); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (wr_addr.size() !== 1) $display("FAIL single_count: got %0d want 1", wr_addr.size()); else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    fb_if.fb_ready = 1'b0;
    clear_log();
    // 12_34_56 -> R 000, G 001, B 010
    strobe(8'd5, 8'd2, 24'h123456);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (fb_if.fb_we !== 1'b1 || fb_if.fb_addr !== 15'd325 || fb_if.fb_data !== 9'h00A)
        $display("FAIL stall_hold%0d: got we=%b addr=%0d data=%h want we=1 addr=325 data=00a",
                 i, fb_if.fb_we, fb_if.fb_addr, fb_if.fb_data);
      else n_pass++;
      tick();
    end
    fb_if.fb_ready = 1'b1;
    wait_idle(20, to);
    n_total++; if (to) $display("FAIL stall_timeout: busy still %b", busy); else n_pass++;
    n_total++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 15'd325 || wr_data[0] !== 9'h00A)
      $display("FAIL stall_write: got n=%0d addr=%0d data=%h want n=1 addr=325 data=00a",
               wr_addr.size(), wr_addr[0], wr_data[0]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit to;
    int bad;
    fb_if.fb_ready = 1'b0;
    clear_log();
    // P0 occupies the write port so the FIFO cannot drain
    strobe(8'd0, 8'd10, 24'hFFFFFF);
    tick();
    for (int i = 1; i <= 10; i++) begin
      pix_valid = 1'b1;
      pix_x     = 8'(i);
      pix_y     = 8'd3;
      pix_rgb   = 24'hFFFFFF;
      tick();
      if (i == 8) begin
        n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_after8: got %b want 0", err_overflow); else n_pass++;
      end
      if (i == 9) begin
        n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_after9: got %b want 1", err_overflow); else n_pass++;
      end
    end
    pix_valid = 1'b0;
    fb_if.fb_ready = 1'b1;
    wait_idle(50, to);
    n_total++; if (to) $display("FAIL ovf_timeout: busy still %b", busy); else n_pass++;
    n_total++; if (wr_addr.size() !== 9) $display("FAIL ovf_count: got %0d want 9", wr_addr.size()); else n_pass++;
    bad = 0;
    if (wr_addr.size() == 9) begin
      if (wr_addr[0] !== 15'd1600) bad++;
      for (int k = 1; k <= 8; k++) if (wr_addr[k] !== 15'(480 + k)) bad++;
    end else bad = 99;
    n_total++; if (bad != 0) $display("FAIL ovf_order: got %0d bad entries want 0", bad); else n_pass++;
    n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", err_overflow); else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", err_overflow); else n_pass++;
  endtask

  task automatic test_oob();
    bit to;
    fb_if.fb_ready = 1'b1;
    clear_log();
    strobe(8'd160, 8'd0, 24'hFFFFFF);
    strobe(8'd0, 8'd120, 24'hFFFFFF);
    tick(); tick(); tick();
    n_total++; if (wr_addr.size() !== 0) $display("FAIL oob_writes: got %0d want 0", wr_addr.size()); else n_pass++;
    n_total++; if (err_oob !== 1'b1) $display("FAIL oob_flag: got %b want 1", err_oob); else n_pass++;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL oob_ovf: got %b want 0", err_overflow); else n_pass++;
    // Bottom-right corner: 119*160+159 = 19199, 00FF00 -> 000_111_000
    strobe(8'd159, 8'd119, 24'h00FF00);
    wait_idle(20, to);
    n_total++;
    if (to || wr_addr.size() !== 1 || wr_addr[0] !== 15'd19199 || wr_data[0] !== 9'h038)
      $display("FAIL oob_corner: got n=%0d addr=%0d data=%h want n=1 addr=19199 data=038",
               wr_addr.size(), wr_addr[0], wr_data[0]);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_total++; if (err_oob !== 1'b0) $display("FAIL oob_clear: got %b want 0", err_oob); else n_pass++;
  endtask

  task automatic test_clear();
    bit to;
    int bad;
    logic [14:0] last_a;
    logic [8:0]  last_d;
    fb_if.fb_ready = 1'b1;
    clear_log();
    bg_color  = 9'h1C0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    strobe(8'd1, 8'd1, 24'hFFFFFF);
    wait_idle(25000, to);
    n_total++; if (to) $display("FAIL clear_timeout: busy still %b", busy); else n_pass++;
    n_total++; if (wr_addr.size() !== 19201) $display("FAIL clear_count: got %0d want 19201", wr_addr.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (i >= wr_addr.size()) begin bad++; continue; end
      if (wr_addr[i] !== 15'(i) || wr_data[i] !== 9'h1C0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL clear_fill: got %0d bad entries want 0", bad); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL clear_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    last_a = (wr_addr.size() > 19200) ? wr_addr[19200] : 15'h7FFF;
    last_d = (wr_data.size() > 19200) ? wr_data[19200] : 9'h000;
    n_total++;
    if (last_a !== 15'd161 || last_d !== 9'h1FF)
      $display("FAIL clear_then_pixel: got addr=%0d data=%h want addr=161 data=1ff", last_a, last_d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    fb_if.fb_ready = 1'b1;
    clear_log();
    bg_color  = 9'h0AA;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (fb_if.fb_we === 1'b1 && fb_if.fb_addr === 15'd500) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_total++; if (!found) $display("FAIL rst_mid_reach: got addr=%0d want 500", fb_if.fb_addr); else n_pass++;
    resetn = 1'b0;
    #1;
    n_total++; if (fb_if.fb_we !== 1'b0) $display("FAIL rst_mid_we: got %b want 0", fb_if.fb_we); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (fb_if.fb_addr !== 15'd0) $display("FAIL rst_mid_addr: got %0d want 0", fb_if.fb_addr); else n_pass++;
    tick(); tick();
    resetn = 1'b1;
    clear_log();
    for (int i = 0; i < 50; i++) tick();
    n_total++; if (wr_addr.size() !== 0) $display("FAIL rst_mid_after: got %0d writes want 0", wr_addr.size()); else n_pass++;
    n_total++; if (done_cnt != 0 || busy !== 1'b0)
      $display("FAIL rst_mid_quiet: got done=%0d busy=%b want 0 0", done_cnt, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pixel_fb_writer
`default_nettype wire
